data_sram_ctrl: RTL

Multi-cycle controller between the MEM stage's RAM port and the board's asynchronous 32-bit data SRAM. It accepts MEM's chip-enable, write-enable, byte-select, address and store-data signals and sequences them into correctly timed SRAM read and write cycles. While an access is in flight it holds the pipeline with a stall request. It returns the full 32-bit read word to MEM, which performs load byte/halfword selection and extension.

---
 rtl/data_sram_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/data_sram_ctrl.sv
// data_sram_ctrl
//   Multi-cycle bridge between the MEM stage RAM port and an asynchronous
//   32-bit data SRAM. A request seen in IDLE is latched and sequenced into a
//   timed SRAM read (READ) or write (SETUP -> WRITE -> HOLD), always ending in
//   a single DONE cycle in which the pipeline stall is released.
//
// Ports
//   clk, rst            : clock, asynchronous active-low reset
//   mem_ce_i/we_i/sel_i : MEM request, direction, byte selects
//   mem_addr_i          : byte address (word address = bits [ADDR_W+1:2])
//   mem_data_i          : lane-aligned store data
//   mem_data_o          : last word read from the SRAM (registered)
//   stall_req_o         : combinational hold request to the pipeline
//   sram_addr_o         : SRAM word address
//   sram_data_o/_oe_o   : SRAM write data and its tristate enable
//   sram_data_i         : SRAM read data from the pad
//   sram_be_n_o         : active-low byte enables
//   sram_ce_n_o/oe_n_o/we_n_o : active-low SRAM strobes
module data_sram_ctrl #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       mem_data_o,
  output logic              stall_req_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_data_o,
  output logic              sram_data_oe_o,
  input  logic [31:0]       sram_data_i,
  output logic [3:0]        sram_be_n_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] SETUP = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  logic [2:0]        state_reg, state_next;
  logic [3:0]        wait_cnt_reg, wait_cnt_next;
  logic [3:0]        sel_reg, sel_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       rdata_reg, rdata_next;
  logic              ce_n_reg, ce_n_next;
  logic              oe_n_reg, oe_n_next;
  logic              we_n_reg, we_n_next;
  logic [3:0]        be_n_reg, be_n_next;
  logic              data_oe_reg, data_oe_next;
  logic [3:0]        lane_be_n;

  // Address bits outside the word address are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr_i[1:0], mem_addr_i[31:ADDR_W+2]};

  // Next-state and latched request copy. MEM inputs are only sampled in IDLE,
  // so later changes (or a flush) cannot disturb an access in flight.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    sel_next      = sel_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    rdata_next    = rdata_reg;
    case (state_reg)
      IDLE: begin
        if (mem_ce_i) begin
          sel_next      = mem_sel_i;
          addr_next     = mem_addr_i[ADDR_W+1:2];
          wdata_next    = mem_data_i;
          wait_cnt_next = '0;
          state_next    = mem_we_i ? SETUP : READ;
        end
      end
      READ: begin
        if (wait_cnt_reg == WAIT_LAST) begin
          rdata_next    = sram_data_i;
          wait_cnt_next = '0;
          state_next    = DONE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 4'd1;
        end
      end
      SETUP: state_next = WRITE;
      WRITE: begin
        if (wait_cnt_reg == WAIT_LAST) begin
          wait_cnt_next = '0;
          state_next    = HOLD;
        end else begin
          wait_cnt_next = wait_cnt_reg + 4'd1;
        end
      end
      HOLD:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Byte enables come from the select copy that will be latched this edge,
  // so SETUP already drives the correct lanes on its first cycle.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_be_n[gi] = ~sel_next[gi];
    end
  endgenerate

  // Strobes are decoded from the state being entered and then registered,
  // which keeps every SRAM pin glitch-free and aligned with its state.
  always_comb begin
    ce_n_next    = 1'b1;
    oe_n_next    = 1'b1;
    we_n_next    = 1'b1;
    be_n_next    = 4'b1111;
    data_oe_next = 1'b0;
    case (state_next)
      READ: begin
        ce_n_next = 1'b0;
        oe_n_next = 1'b0;
        be_n_next = 4'b0000;
      end
      SETUP, HOLD: begin
        ce_n_next    = 1'b0;
        be_n_next    = lane_be_n;
        data_oe_next = 1'b1;
      end
      WRITE: begin
        ce_n_next    = 1'b0;
        we_n_next    = 1'b0;
        be_n_next    = lane_be_n;
        data_oe_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      sel_reg      <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      ce_n_reg     <= 1'b1;
      oe_n_reg     <= 1'b1;
      we_n_reg     <= 1'b1;
      be_n_reg     <= 4'b1111;
      data_oe_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      sel_reg      <= sel_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      rdata_reg    <= rdata_next;
      ce_n_reg     <= ce_n_next;
      oe_n_reg     <= oe_n_next;
      we_n_reg     <= we_n_next;
      be_n_reg     <= be_n_next;
      data_oe_reg  <= data_oe_next;
    end
  end

  // DONE is the single cycle in which the pipeline may advance.
  assign stall_req_o    = rst & mem_ce_i & (state_reg != DONE);
  assign mem_data_o     = rdata_reg;
  assign sram_addr_o    = addr_reg;
  assign sram_data_o    = wdata_reg;
  assign sram_data_oe_o = data_oe_reg;
  assign sram_be_n_o    = be_n_reg;
  assign sram_ce_n_o    = ce_n_reg;
  assign sram_oe_n_o    = oe_n_reg;
  assign sram_we_n_o    = we_n_reg;

endmodule
